rvv_vrf_wr_sched: RTL and testbench

Write-back scheduler for the vector register file. Up to `NUM_REQ` write-back requesters (ALU, MUL/MAC, PMT/RDT, LSU) present register writes with a valid/ready handshake. Each cycle the block grants at most `NUM_WP` of them using rotating priority, never granting two writes to the same register in one cycle. Granted writes are registered onto the VRF write ports, and a one-cycle `v0` update strobe is raised for the dispatch mask path.

---
 rtl/rvv_vrf_wr_sched.sv | 126 ++++++++++++
 tb/tb_rvv_vrf_wr_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_vrf_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : rvv_vrf_wr_sched
// Brief    : Vector register file write-back scheduler. Grants up to NUM_WP
//            requesters per cycle in rotating priority without same-register
//            collisions, and registers the winners onto the VRF write ports.
// Revision : 1.0 - initial release
// ============================================================================
module rvv_vrf_wr_sched #(
    parameter int NUM_REQ = 4,
    parameter int NUM_WP  = 2,
    parameter int VLEN    = 128,
    parameter int IDX_W   = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]         req_addr,
    input  logic [NUM_REQ-1:0][VLEN-1:0]          req_data,
    input  logic [NUM_REQ-1:0][VLEN/8-1:0]        req_be,
    input  logic                                  vrf_stall,
    output logic [NUM_WP-1:0]                     wp_valid,
    output logic [NUM_WP-1:0][IDX_W-1:0]          wp_addr,
    output logic [NUM_WP-1:0][VLEN-1:0]           wp_data,
    output logic [NUM_WP-1:0][VLEN/8-1:0]         wp_be,
    output logic                                  v0_upd,
    output logic [$clog2(NUM_REQ)-1:0]            rr_ptr_o
);

    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam int c_BE_W  = VLEN / 8;

    logic [c_PTR_W-1:0]                 r_rr_ptr;
    logic [NUM_WP-1:0]                  r_wp_valid;
    logic [NUM_WP-1:0][IDX_W-1:0]       r_wp_addr;
    logic [NUM_WP-1:0][VLEN-1:0]        r_wp_data;
    logic [NUM_WP-1:0][c_BE_W-1:0]      r_wp_be;
    logic                               r_v0_upd;

    logic [NUM_REQ-1:0]                 w_grant;
    int                                 w_n_grant;
    logic [NUM_WP-1:0][c_PTR_W-1:0]     w_port_src;
    logic [c_PTR_W-1:0]                 w_last;
    logic [c_PTR_W-1:0]                 w_ptr_next;
    logic                               w_v0_hit;

    // Scan from the priority pointer; the k-th grant lands on write port k.
    always_comb begin : p_scan
        int   idx;
        logic conflict;
        w_grant    = '0;
        w_n_grant  = 0;
        w_port_src = '0;
        w_last     = r_rr_ptr;
        w_v0_hit   = 1'b0;
        idx        = 0;
        conflict   = 1'b0;
        if (!rst && !vrf_stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                conflict = 1'b0;
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (w_grant[j] && (req_addr[j] == req_addr[idx])) begin
                        conflict = 1'b1;
                    end
                end
                if (req_valid[idx] && !conflict && (w_n_grant < NUM_WP)) begin
                    w_grant[idx] = 1'b1;
                    for (int p = 0; p < NUM_WP; p++) begin
                        if (p == w_n_grant) begin
                            w_port_src[p] = c_PTR_W'(idx);
                        end
                    end
                    w_n_grant = w_n_grant + 1;
                    w_last    = c_PTR_W'(idx);
                    if (req_addr[idx] == '0) begin
                        w_v0_hit = 1'b1;
                    end
                end
            end
        end
    end

    assign w_ptr_next = (int'(w_last) == NUM_REQ - 1) ? '0 : (w_last + c_PTR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_wp_valid <= '0;
            r_wp_addr  <= '0;
            r_wp_data  <= '0;
            r_wp_be    <= '0;
            r_v0_upd   <= 1'b0;
        end else begin
            if (w_n_grant > 0) begin
                r_rr_ptr <= w_ptr_next;
            end
            // Idle ports keep their last payload; only the valid bit drops.
            for (int p = 0; p < NUM_WP; p++) begin
                if (p < w_n_grant) begin
                    r_wp_valid[p] <= 1'b1;
                    r_wp_addr[p]  <= req_addr[w_port_src[p]];
                    r_wp_data[p]  <= req_data[w_port_src[p]];
                    r_wp_be[p]    <= req_be[w_port_src[p]];
                end else begin
                    r_wp_valid[p] <= 1'b0;
                end
            end
            r_v0_upd <= w_v0_hit;
        end
    end

    assign req_ready = w_grant;
    assign wp_valid  = r_wp_valid;
    assign wp_addr   = r_wp_addr;
    assign wp_data   = r_wp_data;
    assign wp_be     = r_wp_be;
    assign v0_upd    = r_v0_upd;
    assign rr_ptr_o  = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_rvv_vrf_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvv_vrf_wr_sched
// Brief    : Directed bench for rvv_vrf_wr_sched with a cycle-level reference
//            model and hand-computed spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvv_vrf_wr_sched;

    localparam int c_NUM_REQ = 4;
    localparam int c_NUM_WP  = 2;
    localparam int c_VLEN    = 128;
    localparam int c_IDX_W   = 5;
    localparam int c_BE_W    = c_VLEN / 8;

    logic                                  clk;
    logic                                  rst;
    logic [c_NUM_REQ-1:0]                  req_valid;
    logic [c_NUM_REQ-1:0]                  req_ready;
    logic [c_NUM_REQ-1:0][c_IDX_W-1:0]     req_addr;
    logic [c_NUM_REQ-1:0][c_VLEN-1:0]      req_data;
    logic [c_NUM_REQ-1:0][c_BE_W-1:0]      req_be;
    logic                                  vrf_stall;
    logic [c_NUM_WP-1:0]                   wp_valid;
    logic [c_NUM_WP-1:0][c_IDX_W-1:0]      wp_addr;
    logic [c_NUM_WP-1:0][c_VLEN-1:0]       wp_data;
    logic [c_NUM_WP-1:0][c_BE_W-1:0]       wp_be;
    logic                                  v0_upd;
    logic [1:0]                            rr_ptr_o;

    rvv_vrf_wr_sched #(
        .NUM_REQ(c_NUM_REQ), .NUM_WP(c_NUM_WP), .VLEN(c_VLEN), .IDX_W(c_IDX_W)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_be(req_be), .vrf_stall(vrf_stall),
        .wp_valid(wp_valid), .wp_addr(wp_addr), .wp_data(wp_data), .wp_be(wp_be),
        .v0_upd(v0_upd), .rr_ptr_o(rr_ptr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [c_VLEN-1:0] act, input logic [c_VLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected port contents and pointer, built from the grant rules.
    int                                m_ptr = 0;
    logic [c_NUM_WP-1:0]               m_wv  = '0;
    logic [c_NUM_WP-1:0][c_IDX_W-1:0]  m_wa  = '0;
    logic [c_NUM_WP-1:0][c_VLEN-1:0]   m_wd  = '0;
    logic [c_NUM_WP-1:0][c_BE_W-1:0]   m_wb  = '0;
    logic                              m_v0  = 1'b0;
    bit                                started = 1'b0;

    function automatic void model_scan(input int ptr, output logic [c_NUM_REQ-1:0] gnt,
                                       output int ord[c_NUM_WP], output int n);
        logic [c_IDX_W-1:0] used[$];
        bit clash;
        int i;
        gnt = '0;
        n   = 0;
        for (int p = 0; p < c_NUM_WP; p++) ord[p] = 0;
        if (rst || vrf_stall) return;
        for (int s = 0; s < c_NUM_REQ; s++) begin
            i = (ptr + s) % c_NUM_REQ;
            clash = 1'b0;
            foreach (used[u]) if (used[u] == req_addr[i]) clash = 1'b1;
            if (req_valid[i] && !clash && n < c_NUM_WP) begin
                gnt[i] = 1'b1;
                ord[n] = i;
                n++;
                used.push_back(req_addr[i]);
            end
        end
    endfunction

    always @(posedge clk) begin
        logic [c_NUM_REQ-1:0] g;
        int ord[c_NUM_WP];
        int n;
        if (rst) begin
            m_ptr = 0; m_wv = '0; m_wa = '0; m_wd = '0; m_wb = '0; m_v0 = 1'b0;
        end else begin
            model_scan(m_ptr, g, ord, n);
            m_wv = '0;
            m_v0 = 1'b0;
            for (int p = 0; p < n; p++) begin
                m_wv[p] = 1'b1;
                m_wa[p] = req_addr[ord[p]];
                m_wd[p] = req_data[ord[p]];
                m_wb[p] = req_be[ord[p]];
                if (req_addr[ord[p]] == '0) m_v0 = 1'b1;
            end
            if (n > 0) m_ptr = (ord[n-1] + 1) % c_NUM_REQ;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        logic [c_NUM_REQ-1:0] g;
        int ord[c_NUM_WP];
        int n;
        if (started) begin
            model_scan(m_ptr, g, ord, n);
            check("model_ready", req_ready, g);
            check("model_rr_ptr", rr_ptr_o, m_ptr[1:0]);
            check("model_wp_valid", wp_valid, m_wv);
            check("model_v0_upd", v0_upd, m_v0);
            for (int p = 0; p < c_NUM_WP; p++) begin
                check($sformatf("model_wp_addr%0d", p), wp_addr[p], m_wa[p]);
                check($sformatf("model_wp_data%0d", p), wp_data[p], m_wd[p]);
                check($sformatf("model_wp_be%0d", p), wp_be[p], m_wb[p]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] v, input int a0, input int a1, input int a2, input int a3);
        req_valid = v;
        req_addr[0] = c_IDX_W'(a0);
        req_addr[1] = c_IDX_W'(a1);
        req_addr[2] = c_IDX_W'(a2);
        req_addr[3] = c_IDX_W'(a3);
        for (int i = 0; i < c_NUM_REQ; i++) begin
            req_data[i] = {$urandom, $urandom, $urandom, $urandom};
            req_be[i]   = c_BE_W'($urandom);
        end
    endtask

    logic [c_VLEN-1:0] d0, d1;

    initial begin
        rst = 1'b1;
        vrf_stall = 1'b0;
        drive(4'b1111, 1, 2, 3, 4);
        // Reset held with every requester valid.
        sample();
        check("rst_ready", req_ready, 4'b0000);
        check("rst_wp_valid", wp_valid, 2'b00);
        check("rst_ptr", rr_ptr_o, 0);
        // Rotation: grant sets {0,1}, {2,3}, {0,1}.
        cyc(); rst = 1'b0;
        sample();
        check("rot1_ready", req_ready, 4'b0011);
        check("rot1_ptr", rr_ptr_o, 0);
        check("rot1_wp_valid", wp_valid, 2'b00);
        cyc(); sample();
        check("rot2_ready", req_ready, 4'b1100);
        check("rot2_ptr", rr_ptr_o, 2);
        check("rot2_wp_valid", wp_valid, 2'b11);
        check("rot2_wp_addr0", wp_addr[0], 1);
        check("rot2_wp_addr1", wp_addr[1], 2);
        cyc(); sample();
        check("rot3_ready", req_ready, 4'b0011);
        check("rot3_ptr", rr_ptr_o, 0);
        check("rot3_wp_addr0", wp_addr[0], 3);
        check("rot3_wp_addr1", wp_addr[1], 4);
        // Lone write to v0 from req3.
        cyc(); drive(4'b1000, 1, 2, 3, 0); req_be[3] = '1;
        sample();
        check("v0_ready", req_ready, 4'b1000);
        check("v0_ptr_before", rr_ptr_o, 2);
        // Same-address conflict: req0/req1 both target 5, req2 targets 7.
        cyc(); drive(4'b0111, 5, 5, 7, 0); d0 = req_data[0];
        sample();
        check("conf1_ready", req_ready, 4'b0101);
        check("v0_wp_valid", wp_valid, 2'b01);
        check("v0_wp_addr0", wp_addr[0], 0);
        check("v0_wp_be0", wp_be[0], {c_BE_W{1'b1}});
        check("v0_upd_hi", v0_upd, 1'b1);
        check("v0_ptr_after", rr_ptr_o, 0);
        cyc(); drive(4'b0010, 5, 5, 7, 0); d1 = req_data[1];
        sample();
        check("conf2_ready", req_ready, 4'b0010);
        check("conf2_wp_valid", wp_valid, 2'b11);
        check("conf2_wp_addr0", wp_addr[0], 5);
        check("conf2_wp_data0", wp_data[0], d0);
        check("conf2_wp_addr1", wp_addr[1], 7);
        check("v0_upd_lo", v0_upd, 1'b0);
        check("conf2_ptr", rr_ptr_o, 3);
        cyc(); drive(4'b0000, 5, 5, 7, 0);
        sample();
        check("conf3_wp_valid", wp_valid, 2'b01);
        check("conf3_wp_addr0", wp_addr[0], 5);
        check("conf3_wp_data0", wp_data[0], d1);
        check("conf3_ptr", rr_ptr_o, 2);
        // Stall for two cycles, then release.
        cyc(); vrf_stall = 1'b1; drive(4'b1111, 1, 2, 3, 4);
        sample();
        check("stall1_ready", req_ready, 4'b0000);
        check("stall1_ptr", rr_ptr_o, 2);
        cyc(); sample();
        check("stall2_ready", req_ready, 4'b0000);
        check("stall2_wp_valid", wp_valid, 2'b00);
        check("stall2_ptr", rr_ptr_o, 2);
        cyc(); vrf_stall = 1'b0;
        sample();
        check("unstall_ready", req_ready, 4'b1100);
        check("unstall_wp_valid", wp_valid, 2'b00);
        // Reset in the cycle after a two-port grant.
        cyc(); rst = 1'b1;
        sample();
        check("midrst_wp_valid_pre", wp_valid, 2'b11);
        check("midrst_ready", req_ready, 4'b0000);
        cyc(); rst = 1'b0; drive(4'b0000, 1, 2, 3, 4);
        sample();
        check("midrst_wp_valid_post", wp_valid, 2'b00);
        check("midrst_ptr", rr_ptr_o, 0);
        // All requesters on one register: serialized one per cycle.
        for (int c = 0; c < 5; c++) begin
            cyc(); drive(4'b1111, 9, 9, 9, 9);
        end
        // Mixed traffic with small address space and occasional stalls.
        for (int c = 0; c < 40; c++) begin
            cyc();
            drive(4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            vrf_stall = ($urandom_range(0, 3) == 0);
        end
        cyc(); drive(4'b0000, 0, 0, 0, 0); vrf_stall = 1'b0;
        cyc(); cyc(); sample();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
